// File: rtl/sbrf_pkg.sv
// sbrf_pkg: shared defaults, width helpers and the hardwired-zero index for sb_regfile.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sbrf_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Index of the register that reads as zero when ZERO_REG is enabled.
    localparam int ZERO_IDX = 0;

    // Address width for a DEPTH-entry file (DEPTH is a power of two, >= 2).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold a count of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sbrf_scoreboard.sv
// sbrf_scoreboard: per-register pending bits, busy lookup for two read ports, pending count, protocol error flag.
// Latency: pending bits update on the next edge; busy is combinational; pend_cnt is registered from next-state.
// Backpressure: none; busy feeds the decode stall.
// Optional: define SBRF_ERRCHK_EN to build the sticky err check, otherwise err is tied low.
// Ports: clk, reset_n; ra1/ra2 lookup addresses -> busy1/busy2; iss_en/iss_wa set pending;
//        done_en/done_wa clear pending; pend_cnt popcount; err sticky protocol error.
module sbrf_scoreboard
    import sbrf_pkg::*;
#(
    parameter int   DEPTH    = DEFAULT_DEPTH,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = addr_w(DEPTH),
    localparam int  CW       = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_wa,
    input  logic          done_en,
    input  logic [AW-1:0] done_wa,
    output logic          busy1,
    output logic          busy2,
    output logic [CW-1:0] pend_cnt,
    output logic          err
);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic [CW-1:0]    r_pend_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    // Issue beats completion on the same index: the newly issued op supersedes.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_en && (iss_wa == AW'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end else if (done_en && (done_wa == AW'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            w_pend_nxt[ZERO_IDX] = 1'b0;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    // A register completing this cycle is readable through the bypass, so it is not busy.
    always_comb begin
        busy1 = r_pend[ra1] & ~(done_en && (done_wa == ra1));
        busy2 = r_pend[ra2] & ~(done_en && (done_wa == ra2));
        if (ZERO_REG && (ra1 == AW'(ZERO_IDX))) begin
            busy1 = 1'b0;
        end
        if (ZERO_REG && (ra2 == AW'(ZERO_IDX))) begin
            busy2 = 1'b0;
        end
    end

    assign pend_cnt = r_pend_cnt;

`ifdef SBRF_ERRCHK_EN
    logic r_err;
    logic w_err_done;
    logic w_err_iss;
    logic w_done_z;
    logic w_iss_z;

    // Long-latency ops targeting the hardwired zero register are legal and never tracked,
    // so they are excluded from both checks.
    assign w_done_z   = ZERO_REG && (done_wa == AW'(ZERO_IDX));
    assign w_iss_z    = ZERO_REG && (iss_wa == AW'(ZERO_IDX));
    assign w_err_done = done_en && !r_pend[done_wa] && !w_done_z
                        && !(iss_en && (iss_wa == done_wa));
    assign w_err_iss  = iss_en && r_pend[iss_wa] && !w_iss_z
                        && !(done_en && (done_wa == iss_wa));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_done | w_err_iss;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/sb_regfile.sv
// sb_regfile: WIDTH x DEPTH register file, two bypassed read ports, ALU + long-latency write ports, pending scoreboard.
// Latency: reads are combinational (same-cycle writes bypassed); array and scoreboard update on the next edge.
// Backpressure: none internally; stall tells decode to hold while either source register is pending.
// Optional: define SBRF_ERRCHK_EN to build the sticky protocol-error check driving err.
// Ports: clk, reset_n (async, active low); ra1/ra2 -> rd1/rd2, busy1/busy2, stall;
//        we_a/wa_a/wd_a ALU writeback; iss_en/iss_wa long-latency issue;
//        done_en/done_wa/done_wd long-latency completion; pend_cnt pending count; err protocol error.
module sb_regfile
    import sbrf_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter int   DEPTH    = DEFAULT_DEPTH,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = addr_w(DEPTH),
    localparam int  CW       = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    output logic             stall,
    input  logic             we_a,
    input  logic [AW-1:0]    wa_a,
    input  logic [WIDTH-1:0] wd_a,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_wa,
    input  logic             done_en,
    input  logic [AW-1:0]    done_wa,
    input  logic [WIDTH-1:0] done_wd,
    output logic [CW-1:0]    pend_cnt,
    output logic             err
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Port A is the younger instruction, so it wins an address collision with a completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ZERO_REG && (i == ZERO_IDX)) begin
                    r_mem[i] <= '0;
                end else if (we_a && (wa_a == AW'(i))) begin
                    r_mem[i] <= wd_a;
                end else if (done_en && (done_wa == AW'(i))) begin
                    r_mem[i] <= done_wd;
                end
            end
        end
    end

    logic w_z1;
    logic w_z2;

    assign w_z1 = ZERO_REG && (ra1 == AW'(ZERO_IDX));
    assign w_z2 = ZERO_REG && (ra2 == AW'(ZERO_IDX));

    // Bypass priority mirrors the write priority: port A, then completion, then array.
    assign rd1 = w_z1                           ? '0      :
                 (we_a    && (wa_a    == ra1)) ? wd_a    :
                 (done_en && (done_wa == ra1)) ? done_wd :
                                                  r_mem[ra1];
    assign rd2 = w_z2                           ? '0      :
                 (we_a    && (wa_a    == ra2)) ? wd_a    :
                 (done_en && (done_wa == ra2)) ? done_wd :
                                                  r_mem[ra2];

    sbrf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .iss_en   (iss_en),
        .iss_wa   (iss_wa),
        .done_en  (done_en),
        .done_wa  (done_wa),
        .busy1    (busy1),
        .busy2    (busy2),
        .pend_cnt (pend_cnt),
        .err      (err)
    );

    assign stall = busy1 | busy2;

endmodule

// File: tb/tb_sb_regfile.sv
module tb_sb_regfile;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        stall;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        iss_en;
    logic [4:0]  iss_wa;
    logic        done_en;
    logic [4:0]  done_wa;
    logic [31:0] done_wd;
    logic [5:0]  pend_cnt;
    logic        err;

    int errors = 0;
    int checks = 0;

    sb_regfile #(
        .WIDTH    (32),
        .DEPTH    (32),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .busy1    (busy1),
        .busy2    (busy2),
        .stall    (stall),
        .we_a     (we_a),
        .wa_a     (wa_a),
        .wd_a     (wd_a),
        .iss_en   (iss_en),
        .iss_wa   (iss_wa),
        .done_en  (done_en),
        .done_wa  (done_wa),
        .done_wd  (done_wd),
        .pend_cnt (pend_cnt),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a    = 1'b0;
        wa_a    = '0;
        wd_a    = '0;
        iss_en  = 1'b0;
        iss_wa  = '0;
        done_en = 1'b0;
        done_wa = '0;
        done_wd = '0;
    endtask

    task automatic test_reset();
        idle();
        ra1 = 5'd5;
        ra2 = 5'd6;
        #1;
        checks++; if (rd1 !== 32'h0)     begin errors++; $display("FAIL reset_rd1: got %h want %h", rd1, 32'h0); end
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        // write r5 and issue r6 in one cycle
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234;
        iss_en = 1'b1; iss_wa = 5'd6;
        step();
        idle();
        #1;
        checks++; if (rd1 !== 32'h1234)  begin errors++; $display("FAIL pre_reset_rd1: got %h want %h", rd1, 32'h1234); end
        checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL pre_reset_pend_cnt: got %0d want 1", pend_cnt); end
        checks++; if (busy2 !== 1'b1)    begin errors++; $display("FAIL pre_reset_busy2: got %b want 1", busy2); end
        // asynchronous reset mid-cycle, checked before the next edge
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (rd1 !== 32'h0)     begin errors++; $display("FAIL midreset_rd1: got %h want %h", rd1, 32'h0); end
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL midreset_pend_cnt: got %0d want 0", pend_cnt); end
        checks++; if (busy2 !== 1'b0)    begin errors++; $display("FAIL midreset_busy2: got %b want 0", busy2); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL midreset_err: got %b want 0", err); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        idle();
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hDEADBEEF;
        ra1 = 5'd7; ra2 = 5'd7;
        #1;
        checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1: got %h want %h", rd1, 32'hDEADBEEF); end
        checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd2: got %h want %h", rd2, 32'hDEADBEEF); end
        step();
        idle();
        #1;
        checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL array_rd1: got %h want %h", rd1, 32'hDEADBEEF); end
    endtask

    task automatic test_scoreboard();
        idle();
        ra1 = 5'd9; ra2 = 5'd9;
        iss_en = 1'b1; iss_wa = 5'd9;
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_c0_busy1: got %b want 0", busy1); end
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1)    begin errors++; $display("FAIL sb_c1_busy1: got %b want 1", busy1); end
        checks++; if (busy2 !== 1'b1)    begin errors++; $display("FAIL sb_c1_busy2: got %b want 1", busy2); end
        checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL sb_c1_stall: got %b want 1", stall); end
        checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_c1_pend_cnt: got %0d want 1", pend_cnt); end
        step();
        step();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_c3_busy1: got %b want 1", busy1); end
        step();
        done_en = 1'b1; done_wa = 5'd9; done_wd = 32'h55;
        #1;
        checks++; if (busy1 !== 1'b0)    begin errors++; $display("FAIL sb_c4_busy1: got %b want 0", busy1); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL sb_c4_stall: got %b want 0", stall); end
        checks++; if (rd1 !== 32'h55)    begin errors++; $display("FAIL sb_c4_rd1: got %h want %h", rd1, 32'h55); end
        checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_c4_pend_cnt: got %0d want 1", pend_cnt); end
        step();
        idle();
        #1;
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_c5_pend_cnt: got %0d want 0", pend_cnt); end
        checks++; if (rd1 !== 32'h55)    begin errors++; $display("FAIL sb_c5_rd1: got %h want %h", rd1, 32'h55); end
        checks++; if (busy1 !== 1'b0)    begin errors++; $display("FAIL sb_c5_busy1: got %b want 0", busy1); end
    endtask

    task automatic test_collision();
        idle();
        ra1 = 5'd3; ra2 = 5'd0;
        iss_en = 1'b1; iss_wa = 5'd3;
        step();
        idle();
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hA;
        done_en = 1'b1; done_wa = 5'd3; done_wd = 32'hB;
        #1;
        checks++; if (rd1 !== 32'hA) begin errors++; $display("FAIL coll_wr_bypass: got %h want %h", rd1, 32'hA); end
        step();
        idle();
        #1;
        checks++; if (rd1 !== 32'hA)     begin errors++; $display("FAIL coll_wr_array: got %h want %h", rd1, 32'hA); end
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL coll_wr_pend_cnt: got %0d want 0", pend_cnt); end
        // issue and completion to an already-pending r3 in the same cycle
        iss_en = 1'b1; iss_wa = 5'd3;
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL coll_pend_busy: got %b want 1", busy1); end
        iss_en = 1'b1; iss_wa = 5'd3;
        done_en = 1'b1; done_wa = 5'd3; done_wd = 32'hC;
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL coll_issdone_busy: got %b want 0", busy1); end
        checks++; if (rd1 !== 32'hC)  begin errors++; $display("FAIL coll_issdone_rd1: got %h want %h", rd1, 32'hC); end
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1)    begin errors++; $display("FAIL coll_issdone_kept: got %b want 1", busy1); end
        checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL coll_issdone_cnt: got %0d want 1", pend_cnt); end
        checks++; if (rd1 !== 32'hC)     begin errors++; $display("FAIL coll_issdone_arr: got %h want %h", rd1, 32'hC); end
        done_en = 1'b1; done_wa = 5'd3; done_wd = 32'hD;
        step();
        idle();
        #1;
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL coll_final_cnt: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_zero();
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF;
        iss_en = 1'b1; iss_wa = 5'd0;
        #1;
        checks++; if (rd1 !== 32'h0)  begin errors++; $display("FAIL zero_bypass_rd1: got %h want %h", rd1, 32'h0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy1_c0: got %b want 0", busy1); end
        step();
        idle();
        #1;
        checks++; if (rd1 !== 32'h0)     begin errors++; $display("FAIL zero_rd1: got %h want %h", rd1, 32'h0); end
        checks++; if (busy2 !== 1'b0)    begin errors++; $display("FAIL zero_busy2: got %b want 0", busy2); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL zero_pend_cnt: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_back_to_back();
        idle();
        iss_en = 1'b1; iss_wa = 5'd11;
        step();
        idle();
        ra1 = 5'd10; ra2 = 5'd11;
        we_a = 1'b1; wa_a = 5'd10; wd_a = 32'h1010;
        done_en = 1'b1; done_wa = 5'd11; done_wd = 32'h1111;
        #1;
        checks++; if (rd1 !== 32'h1010) begin errors++; $display("FAIL b2b_byp_rd1: got %h want %h", rd1, 32'h1010); end
        checks++; if (rd2 !== 32'h1111) begin errors++; $display("FAIL b2b_byp_rd2: got %h want %h", rd2, 32'h1111); end
        step();
        idle();
        #1;
        checks++; if (rd1 !== 32'h1010)  begin errors++; $display("FAIL b2b_arr_rd1: got %h want %h", rd1, 32'h1010); end
        checks++; if (rd2 !== 32'h1111)  begin errors++; $display("FAIL b2b_arr_rd2: got %h want %h", rd2, 32'h1111); end
        checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL b2b_pend_cnt: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef SBRF_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        idle();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", err); end
        done_en = 1'b1; done_wa = 5'd12; done_wd = 32'h77;
        step();
        idle();
        #1;
        checks++; if (err !== exp_err) begin errors++; $display("FAIL err_set: got %b want %b", err, exp_err); end
        step();
        step();
        checks++; if (err !== exp_err) begin errors++; $display("FAIL err_sticky: got %b want %b", err, exp_err); end
    endtask

    initial begin
        reset_n = 1'b0;
        ra1 = '0;
        ra2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_zero();
        test_back_to_back();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
